// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_BITS LSB first, optional parity, stop.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry input FIFO ahead of the FSM.
module uart_tx_frame #(
  parameter int CLOCK_FREQUENCY = 10_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clockIN,
  input  logic       resetIN,
  input  logic [8:0] txDataIN,
  input  logic       txValidIN,
  output logic       txReadyOUT,
  output logic       txBusyOUT,
  output logic       txOUT
);

  localparam int BAUD_DIV = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CW = $clog2(BAUD_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] LASTDATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LASTSTOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_t;

  state_t state;
  state_t stateNext;

  logic [CW-1:0] tickCnt;
  logic tick;
  logic [BW-1:0] bitIdx;
  logic [DATA_BITS-1:0] shiftData;
  logic parityBit;
  logic startReq;
  logic [DATA_BITS-1:0] startData;
  logic push;
  logic unusedHi;

  // Payload bits above DATA_BITS are ignored by design.
  assign unusedHi = ^txDataIN;
  assign tick = (tickCnt == '0);

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULLCNT = (AW+1)'(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0] count;
  logic full;
  logic empty;
  logic pop;

  assign full = (count == FULLCNT);
  assign empty = (count == '0);
  assign txReadyOUT = !full && !resetIN;
  assign push = txValidIN && txReadyOUT;
  assign pop = (state == IDLE) && !empty;
  assign startReq = pop;
  assign startData = mem[rdPtr];
  assign txBusyOUT = (state != IDLE) || !empty;

  always_ff @(posedge clockIN) begin
    if (push) mem[wrPtr] <= txDataIN[DATA_BITS-1:0];
  end

  always_ff @(posedge clockIN or posedge resetIN) begin
    if (resetIN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10: count <= count + 1'b1;
        2'b01: count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
`else
  localparam int unusedDepth = FIFO_DEPTH;

  assign txReadyOUT = (state == IDLE) && !resetIN;
  assign push = txValidIN && txReadyOUT;
  assign startReq = push;
  assign startData = txDataIN[DATA_BITS-1:0];
  assign txBusyOUT = (state != IDLE);
`endif

  always_ff @(posedge clockIN or posedge resetIN) begin
    if (resetIN) state <= IDLE;
    else state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (startReq) stateNext = START;
      START: if (tick) stateNext = DATA;
      DATA: begin
        if (tick && bitIdx == LASTDATA)
          stateNext = (PARITY != 0) ? PAR : STOP;
      end
      PAR: if (tick) stateNext = STOP;
      STOP: begin
        if (tick && bitIdx == LASTSTOP)
          stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Bit index restarts whenever the state changes, so it serves DATA and STOP.
  always_ff @(posedge clockIN or posedge resetIN) begin
    if (resetIN) begin
      tickCnt <= '0;
      bitIdx <= '0;
      shiftData <= '0;
      parityBit <= 1'b0;
    end else if (state == IDLE) begin
      tickCnt <= startReq ? RELOAD : '0;
      bitIdx <= '0;
      if (startReq) begin
        shiftData <= startData;
        parityBit <= (PARITY == 1) ? ~^startData : ^startData;
      end
    end else begin
      tickCnt <= tick ? RELOAD : tickCnt - 1'b1;
      if (tick) begin
        bitIdx <= (stateNext != state) ? '0 : bitIdx + 1'b1;
        if (state == DATA) shiftData <= shiftData >> 1;
      end
    end
  end

  always_comb begin
    txOUT = 1'b1;
    unique case (state)
      START: txOUT = 1'b0;
      DATA: txOUT = shiftData[0];
      PAR: txOUT = parityBit;
      default: txOUT = 1'b1;
    endcase
  end

endmodule
